alu_flag_stage: RTL and testbench
=================================

// Module: alu_flag_stage
// PURPOSE
//  Registered output stage directly downstream of the ALU operation units (shift, add, logic).
//  Captures the raw result plus carry/overflow, derives the N/Z/C/V status flags and buffers
//  them in a 2-entry skid FIFO with valid/ready handshakes on both sides.
//  Consumers are the register-file writeback and the flags register.
// PARAMETERS
//  ancho   4   data width of the ALU result in bits (>=2)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous reset, active low
//  alu_valid    in   1      upstream result valid
//  alu_ready    out  1      stage can accept a result this cycle
//  aluresult    in   ancho  result from the selected ALU unit
//  aluflags     in   1      carry / shifted-out bit from the ALU unit
//  aluovf       in   1      signed overflow from the ALU unit (0 for shift/logic ops)
//  out_valid    out  1      buffered result available
//  out_ready    in   1      downstream accepts head entry
//  out_result   out  ancho  head entry result
//  out_flags    out  4      head entry flags {N,Z,C,V}
// BEHAVIOUR
//  - One clock; rst_n is asynchronous, active low. While rst_n=0: count=0, out_valid=0,
//    out_result=0, out_flags=4'b0000, alu_ready=0. First edge after release: alu_ready=1.
//  - Push when alu_valid & alu_ready. Pop when out_valid & out_ready.
//  - Flags are computed at push: N=aluresult[ancho-1], Z=(aluresult==0), C=aluflags, V=aluovf.
//  - Storage: 2 entries, head/tail pointers wrap modulo 2, occupancy count 0..2.
//  - alu_ready = (count<2), derived from registered count only (no comb path from out_ready).
//  - out_valid = (count!=0). Latency: push at edge k -> out_valid=1 after edge k.
//    There is no same-cycle bypass.
//  - Push+pop in the same cycle at count=1: count stays 1, new entry becomes head next cycle.
//  - Push+pop at count=0 is impossible (out_valid=0). Push at count=2 is blocked (alu_ready=0).
//  - Pop at count=2 frees a slot; alu_ready rises on the following cycle.
//  - out_result/out_flags stay stable while out_valid=1 and out_ready=0.
//    When count=0 they hold their last value.
//  - alu_valid/aluresult are don't-care while alu_ready=0; no data is dropped or duplicated.
//  - Reset mid-operation discards all entries immediately (asynchronous).
// CONFIGURATION
//  STICKY_FLAGS_EN defined:
//  - Adds input flag_clr (1) and output sticky_flags (4).
//  - sticky_flags resets to 0. On each pop it ORs in out_flags.
//  - flag_clr=1 alone clears it to 0.
//  - flag_clr=1 together with a pop loads exactly that pop's out_flags.
//  STICKY_FLAGS_EN undefined: both ports and their logic are absent; core behaviour is identical.
// TESTING
//  1 Reset: hold rst_n=0, drive alu_valid=1 -> alu_ready=0, out_valid=0, out_flags=0.
//    Release -> alu_ready=1 next edge.
//  2 Single op, ancho=4: push 4'b1000 C=1 V=0 -> next cycle out_result=4'b1000,
//    out_flags=4'b1010.
//  3 Zero: push 4'b0000 C=0 V=0 -> out_flags=4'b0100.
//  4 Backpressure: out_ready=0, push 4'h3 then 4'h5 -> alu_ready=0, out_result=4'h3 held.
//    Raise out_ready -> 4'h3 then 4'h5 in order; alu_ready returns to 1.
//  5 Streaming: alu_valid=1 and out_ready=1 for 8 cycles with values 0..7 -> out_result=0..7,
//    one per cycle after 1-cycle latency, count never exceeds 1.
//  6 (STICKY_FLAGS_EN) pop flags 4'b1010 then 4'b0001 -> sticky_flags=4'b1011.
//    Assert flag_clr together with a pop of 4'b0100 -> sticky_flags=4'b0100.

Source files
------------

// File: rtl/alu_flag_stage_if.sv
// Handshake bundle for alu_flag_stage: ALU-side push channel and consumer-side pop channel.
// The stage uses the slave modport; whatever drives it uses master.
interface alu_flag_stage_if #(
    parameter int unsigned ancho = 4
);
    logic             alu_valid;
    logic             alu_ready;
    logic [ancho-1:0] aluresult;
    logic             aluflags;
    logic             aluovf;
    logic             out_valid;
    logic             out_ready;
    logic [ancho-1:0] out_result;
    logic [3:0]       out_flags;

    modport slave (
        input  alu_valid, aluresult, aluflags, aluovf, out_ready,
        output alu_ready, out_valid, out_result, out_flags
    );

    modport master (
        output alu_valid, aluresult, aluflags, aluovf, out_ready,
        input  alu_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_flag_stage.sv
// ALU output stage: derives {N,Z,C,V} at push and buffers results in a 2-entry skid FIFO.
// Optional STICKY_FLAGS_EN adds flag_clr/sticky_flags accumulating popped flags.
module alu_flag_stage #(
    parameter int unsigned ancho = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef STICKY_FLAGS_EN
    input  logic                flag_clr,
    output logic [3:0]          sticky_flags,
`endif
    alu_flag_stage_if.slave     bus
);
    localparam int unsigned DEPTH = 2;

    logic             en_q, en_d;
    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [ancho-1:0] res_q [DEPTH];
    logic [ancho-1:0] res_d [DEPTH];
    logic [3:0]       flg_q [DEPTH];
    logic [3:0]       flg_d [DEPTH];
    logic [ancho-1:0] out_res_q, out_res_d;
    logic [3:0]       out_flg_q, out_flg_d;
    logic             push, pop;
    logic [3:0]       new_flags;

    // en_q keeps alu_ready low through reset and rises on the first edge after release
    assign bus.alu_ready  = en_q && (count_q != 2'd2);
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.out_result = out_res_q;
    assign bus.out_flags  = out_flg_q;

    assign push      = bus.alu_valid && bus.alu_ready;
    assign pop       = bus.out_valid && bus.out_ready;
    assign new_flags = {bus.aluresult[ancho-1], (bus.aluresult == '0), bus.aluflags, bus.aluovf};

    always_comb begin
        en_d      = 1'b1;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        res_d     = res_q;
        flg_d     = flg_q;
        out_res_d = out_res_q;
        out_flg_d = out_flg_q;

        if (push) begin
            res_d[tail_q] = bus.aluresult;
            flg_d[tail_q] = new_flags;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Outputs are registered copies of the next head so they hold their last value when empty
        if (count_d != 2'd0) begin
            out_res_d = res_d[head_d];
            out_flg_d = flg_d[head_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            count_q   <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            out_res_q <= '0;
            out_flg_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            en_q      <= en_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
            out_res_q <= out_res_d;
            out_flg_q <= out_flg_d;
        end
    end

`ifdef STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    assign sticky_flags = sticky_q;

    always_comb begin
        sticky_d = sticky_q;
        if (pop) begin
            sticky_d = flag_clr ? out_flg_q : (sticky_q | out_flg_q);
        end else if (flag_clr) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`endif
endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage (ancho=4): directed cases, streaming, random traffic.
module tb_alu_flag_stage;
    logic clk;
    logic rst_n;
`ifdef STICKY_FLAGS_EN
    logic       flag_clr;
    logic [3:0] sticky_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [$];
    int         mdl_cnt = 0;
    logic       mdl_en;

    alu_flag_stage_if #(.ancho(4)) bus ();

    alu_flag_stage #(.ancho(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef STICKY_FLAGS_EN
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Model of the first-edge ready enable
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl_en <= 1'b0;
        else        mdl_en <= 1'b1;
    end

    // Monitor: handshakes decided by the model's own ready/valid, evaluated mid-cycle
    always @(negedge clk) begin
        logic       exp_ready, exp_valid, do_push, do_pop;
        logic [7:0] e;
        if (!rst_n) begin
            sb.delete();
            mdl_cnt = 0;
        end else begin
            exp_ready = mdl_en && (mdl_cnt < 2);
            exp_valid = (mdl_cnt != 0);
            chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, exp_ready});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
            do_pop  = exp_valid && bus.out_ready;
            do_push = exp_ready && bus.alu_valid;
            if (do_pop) begin
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pop_data", {24'd0, bus.out_result, bus.out_flags}, {24'd0, e});
                end
            end
            if (do_push) begin
                sb.push_back({bus.aluresult, bus.aluresult[3], (bus.aluresult == 4'd0),
                              bus.aluflags, bus.aluovf});
            end
            mdl_cnt = mdl_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] r, input logic c, input logic o);
        bus.alu_valid = v;
        bus.aluresult = r;
        bus.aluflags  = c;
        bus.aluovf    = o;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b1, 4'h7, 1'b1, 1'b1);
`ifdef STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        // Reset state with alu_valid asserted
        step();
        step();
        chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_flags", {28'd0, bus.out_flags}, 32'd0);
        chk("rst_out_result", {28'd0, bus.out_result}, 32'd0);
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_ready_low", {31'd0, bus.alu_ready}, 32'd0);
        step();
        chk("rel_ready_high", {31'd0, bus.alu_ready}, 32'd1);

        // Single op: N and C set
        set_in(1'b1, 4'b1000, 1'b1, 1'b0);
        step();
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t2_result", {28'd0, bus.out_result}, 32'h8);
        chk("t2_flags", {28'd0, bus.out_flags}, 32'hA);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t2_empty", {31'd0, bus.out_valid}, 32'd0);
        chk("t2_hold", {28'd0, bus.out_result}, 32'h8);

        // Zero result
        set_in(1'b1, 4'b0000, 1'b0, 1'b0);
        step();
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t3_flags", {28'd0, bus.out_flags}, 32'h4);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Backpressure: fill both slots, blocked push ignored
        set_in(1'b1, 4'h3, 1'b0, 1'b0);
        step();
        set_in(1'b1, 4'h5, 1'b0, 1'b0);
        step();
        chk("t4_full_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("t4_head", {28'd0, bus.out_result}, 32'h3);
        set_in(1'b1, 4'h9, 1'b1, 1'b1);
        step();
        chk("t4_head_held", {28'd0, bus.out_result}, 32'h3);
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("t4_second", {28'd0, bus.out_result}, 32'h5);
        chk("t4_ready_back", {31'd0, bus.alu_ready}, 32'd1);
        step();
        bus.out_ready = 1'b0;
        chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);

        // Streaming with push+pop at count=1
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 4'(i), 1'b0, 1'b0);
            step();
            chk("t5_ready", {31'd0, bus.alu_ready}, 32'd1);
            chk("t5_result", {28'd0, bus.out_result}, i);
        end
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        chk("t5_drained", {31'd0, bus.out_valid}, 32'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.out_ready = 1'b0;
        chk("rand_sb_empty", sb.size(), 32'd0);

        // Asynchronous reset mid-operation
        set_in(1'b1, 4'hC, 1'b1, 1'b0);
        step();
        set_in(1'b1, 4'h6, 1'b0, 1'b1);
        step();
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("mid_rst_result", {28'd0, bus.out_result}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("mid_rel_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("mid_rel_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef STICKY_FLAGS_EN
        set_in(1'b1, 4'b1000, 1'b1, 1'b0);
        step();
        set_in(1'b1, 4'b0001, 1'b0, 1'b1);
        step();
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        step();
        bus.out_ready = 1'b0;
        chk("sticky_or", {28'd0, sticky_flags}, 32'hB);
        set_in(1'b1, 4'b0000, 1'b0, 1'b0);
        step();
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        flag_clr      = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("sticky_clr_pop", {28'd0, sticky_flags}, 32'h4);
        step();
        flag_clr = 1'b0;
        chk("sticky_clr", {28'd0, sticky_flags}, 32'h0);
`endif

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
